// File: rtl/rx_core.sv
// rx_core: UART 8N1 receive core. Turns the serial rx line back into bytes.
// Each byte is offered on a valid/ready handshake. Single-cycle pulses report
// every stop-bit sample, framing errors and overruns.
module rx_core #(
  parameter int CLKS_PER_BIT = 16,  // must be >= 4 and even
  parameter int DATA_BITS    = 8
) (
  input  logic                 rx_clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 accept;

  // Two-flop synchroniser; it resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old value,
      // forming a real two-stage pipeline rather than a single flop.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign accept = valid_q & rx_ready;

  // Next-state logic: frame sequencing, mid-bit sampling, handshake and flags.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (accept) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Mid start bit: a high line here means the low edge was a glitch.
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Re-arm at mid-stop so a back-to-back start bit is not missed.
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
          end else if (!valid_q || accept) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_done      = done_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_rx_core.sv
// tb_rx_core: drives 8N1 frames into rx_core and checks the bytes and
// status pulses against expectations derived from the frame contents.
module tb_rx_core;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic          rx_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_done;
  logic          rx_frame_err;
  logic          rx_overrun;

  rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .rx_clk      (rx_clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_done     (rx_done),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  always #5 rx_clk = ~rx_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed event counts and accepted bytes, gathered away from the clock edge.
  int            n_done, n_ferr, n_ovr, n_valid_cyc;
  logic [DB-1:0] rx_q[$];

  always @(negedge rx_clk) begin
    if (reset_n) begin
      if (rx_done)      n_done++;
      if (rx_frame_err) n_ferr++;
      if (rx_overrun)   n_ovr++;
      if (rx_valid)     n_valid_cyc++;
      if (rx_valid && rx_ready) rx_q.push_back(rx_data);
      if (rx_frame_err || rx_overrun)
        check("flag_excl_with_done", {30'd0, rx_frame_err & rx_overrun, rx_done}, 32'h1);
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge rx_clk);
    #2;
  endtask

  task automatic clear_stats();
    n_done = 0; n_ferr = 0; n_ovr = 0; n_valid_cyc = 0;
    rx_q.delete();
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge rx_clk);
    check({tag, "_data"},  {24'd0, rx_data}, 32'h0);
    check({tag, "_flags"}, {28'd0, rx_valid, rx_done, rx_frame_err, rx_overrun}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] b;
  int            n_bad;
  logic          stop_bit;

  initial begin
    void'($urandom(32'h5eed_2024));
    n_done = 0; n_ferr = 0; n_ovr = 0; n_valid_cyc = 0;

    // Reset state
    tick(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick(2 * CPB);

    // 1: single byte with consumer ready
    clear_stats();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    tick(3 * CPB);
    check("t1_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t1_data", {24'd0, rx_q[0]}, 32'hA5);
    check("t1_valid_cycles", n_valid_cyc, 1);
    check("t1_done", n_done, 1);
    check("t1_errs", n_ferr + n_ovr, 0);

    // 2: back-to-back with consumer stalled -> overrun, first byte held
    clear_stats();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    tick(3 * CPB);
    @(negedge rx_clk);
    check("t2_valid_held", {31'd0, rx_valid}, 32'h1);
    check("t2_data_held", {24'd0, rx_data}, 32'h3C);
    check("t2_overrun", n_ovr, 1);
    check("t2_done", n_done, 2);
    check("t2_ferr", n_ferr, 0);
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    check("t2_accept_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t2_accept_data", {24'd0, rx_q[0]}, 32'h3C);
    @(negedge rx_clk);
    check("t2_valid_drop", {31'd0, rx_valid}, 32'h0);

    // 3: stop bit low -> framing error, nothing delivered
    clear_stats();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    tick(3 * CPB);
    check("t3_ferr", n_ferr, 1);
    check("t3_done", n_done, 1);
    check("t3_valid_cycles", n_valid_cyc, 0);
    check("t3_ovr", n_ovr, 0);

    // 4: one-clock glitch -> false start, then a good frame
    clear_stats();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(3 * CPB);
    check("t4_glitch_done", n_done, 0);
    check("t4_glitch_valid", n_valid_cyc, 0);
    send_frame(8'h0F, 1'b1);
    tick(3 * CPB);
    check("t4_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t4_data", {24'd0, rx_q[0]}, 32'h0F);
    check("t4_errs", n_ferr + n_ovr, 0);

    // 5: reset during data bit 3 of 0xFF, then a clean frame
    clear_stats();
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + CPB / 2);
    reset_n = 1'b0;
    tick(1);
    check_outputs_zero("t5_reset");
    tick(2);
    reset_n = 1'b1;
    tick(3 * CPB);
    send_frame(8'h12, 1'b1);
    tick(3 * CPB);
    check("t5_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t5_data", {24'd0, rx_q[0]}, 32'h12);
    check("t5_errs", n_ferr + n_ovr, 0);

    // 6: 100 random frames, some with a bad stop bit, random gaps
    clear_stats();
    exp_q.delete();
    n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      b = DB'($urandom);
      stop_bit = ($urandom_range(0, 9) != 0);
      send_frame(b, stop_bit);
      if (stop_bit) begin
        exp_q.push_back(b);
        tick($urandom_range(0, 2 * CPB));
      end else begin
        n_bad++;
        tick(2 * CPB + $urandom_range(0, CPB));
      end
    end
    tick(3 * CPB);
    check("t6_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("t6_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    check("t6_done", n_done, 100);
    check("t6_ferr", n_ferr, n_bad);
    check("t6_ovr", n_ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
